// File: rtl/seg_scan_if.sv
// Bundle between the processor's segment-code outputs and the scan driver.
// The master side supplies the codes and the enable; the slave side drives the pins.
interface seg_scan_if;
  logic       en;
  logic [6:0] seg1_in;
  logic [6:0] seg2_in;
  logic [6:0] seg_out;
  logic [1:0] an_out;
  logic       frame_tick;

  modport master (
    output en, seg1_in, seg2_in,
    input  seg_out, an_out, frame_tick
  );

  modport slave (
    input  en, seg1_in, seg2_in,
    output seg_out, an_out, frame_tick
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Two-digit time-multiplexed 7-segment driver with per-frame input snapshot,
// inter-digit blanking and fully registered pin outputs.
module seg_scan_driver #(
  parameter int SHOW_CYC   = 50000,
  parameter int BLANK_CYC  = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  seg_scan_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHOW1  = 3'd1,
    BLANK1 = 3'd2,
    SHOW2  = 3'd3,
    BLANK2 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
  localparam logic             NO_BLANK   = (BLANK_CYC == 0);
  localparam logic [6:0]       SEG_INV    = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0]       AN_INV     = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       snap1_q, snap1_d;
  logic [6:0]       snap2_q, snap2_d;
  logic [6:0]       seg_out_q, seg_out_d;
  logic [1:0]       an_out_q, an_out_d;
  logic             frame_tick_q, frame_tick_d;
  logic             take_snap_s;

  // Next-state, dwell counter and snapshot control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    take_snap_s = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          take_snap_s = 1'b1;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = SHOW1;
        end
        SHOW1: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = NO_BLANK ? SHOW2 : BLANK1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        BLANK1: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = SHOW2;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SHOW2: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_d       = {CNT_W{1'b0}};
            take_snap_s = NO_BLANK;
            state_d     = NO_BLANK ? SHOW1 : BLANK2;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        BLANK2: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d       = {CNT_W{1'b0}};
            take_snap_s = 1'b1;
            state_d     = SHOW1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = IDLE;
        end
      endcase
    end
  end

  // Pin values are decoded from the next state so they change together with it.
  always_comb begin
    snap1_d      = take_snap_s ? bus.seg1_in : snap1_q;
    snap2_d      = take_snap_s ? bus.seg2_in : snap2_q;
    frame_tick_d = take_snap_s;
    case (state_d)
      SHOW1: begin
        seg_out_d = snap1_d ^ SEG_INV;
        an_out_d  = 2'b01 ^ AN_INV;
      end
      SHOW2: begin
        seg_out_d = snap2_d ^ SEG_INV;
        an_out_d  = 2'b10 ^ AN_INV;
      end
      default: begin
        seg_out_d = SEG_INV;
        an_out_d  = AN_INV;
      end
    endcase
  end

  // State, counter, snapshots and registered pin outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      snap1_q      <= 7'h00;
      snap2_q      <= 7'h00;
      seg_out_q    <= SEG_INV;
      an_out_q     <= AN_INV;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      snap1_q      <= snap1_d;
      snap2_q      <= snap2_d;
      seg_out_q    <= seg_out_d;
      an_out_q     <= an_out_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.seg_out    = seg_out_q;
  assign bus.an_out     = an_out_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: instance A (SHOW=4, BLANK=2, active-low) and
// instance B (SHOW=4, no blanking, active-high) share one clock and reset.
module tb_seg_scan_driver;
  logic clk;
  logic rst;

  seg_scan_if ifa ();
  seg_scan_if ifb ();

  seg_scan_driver #(.SHOW_CYC(4), .BLANK_CYC(2), .ACTIVE_LOW(1), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  seg_scan_driver #(.SHOW_CYC(4), .BLANK_CYC(0), .ACTIVE_LOW(0), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {frame_tick, an_out, seg_out} per cycle.
  logic [9:0] qa[$];
  logic [9:0] qb[$];
  int n_checks = 0;
  int n_errors = 0;

  localparam logic [9:0] IDLE_A = {1'b0, 2'b11, 7'h7F};

  task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input bit to_b, input logic [9:0] v);
    if (to_b) qb.push_back(v);
    else      qa.push_back(v);
  endtask

  // Expected pin sequence for one whole frame, derived from the parameters of A or B.
  task automatic push_frame(input bit to_b, input logic [6:0] s1, input logic [6:0] s2);
    logic [6:0] inv;
    logic [1:0] an1, an2, anoff;
    int blank;
    blank = to_b ? 0 : 2;
    inv   = to_b ? 7'h00 : 7'h7F;
    an1   = to_b ? 2'b01 : 2'b10;
    an2   = to_b ? 2'b10 : 2'b01;
    anoff = to_b ? 2'b00 : 2'b11;
    for (int i = 0; i < 4; i++) push(to_b, {(i == 0), an1, s1 ^ inv});
    for (int i = 0; i < blank; i++) push(to_b, {1'b0, anoff, inv});
    for (int i = 0; i < 4; i++) push(to_b, {1'b0, an2, s2 ^ inv});
    for (int i = 0; i < blank; i++) push(to_b, {1'b0, anoff, inv});
  endtask

  // Advance n clocks, comparing each DUT against its queue just after the edge.
  task automatic step(input int n);
    logic [9:0] e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check_val("dut_a_pins", {ifa.frame_tick, ifa.an_out, ifa.seg_out}, e);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check_val("dut_b_pins", {ifb.frame_tick, ifb.an_out, ifb.seg_out}, e);
        check_val("dut_b_an_not_both", {9'd0, (ifb.an_out == 2'b11)}, 10'd0);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    ifa.en      = 1'b0;
    ifa.seg1_in = 7'h06;
    ifa.seg2_in = 7'h5B;
    ifb.en      = 1'b0;
    ifb.seg1_in = 7'h06;
    ifb.seg2_in = 7'h5B;

    // Reset held, then idle with en low and arbitrary inputs.
    for (int i = 0; i < 3; i++) push(1'b0, IDLE_A);
    step(3);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ifa.seg1_in = 7'($urandom);
      ifa.seg2_in = 7'($urandom);
      push(1'b0, IDLE_A);
      step(1);
    end

    // Normal scan, with seg1 changed during SHOW2 of the first frame.
    ifa.seg1_in = 7'h06;
    ifa.seg2_in = 7'h5B;
    ifa.en      = 1'b1;
    push_frame(1'b0, 7'h06, 7'h5B);
    step(7);
    ifa.seg1_in = 7'h3F;
    step(5);
    push_frame(1'b0, 7'h3F, 7'h5B);
    step(12);

    // Enable drop on the second SHOW1 cycle, then re-enable.
    push(1'b0, {1'b1, 2'b10, 7'h40});
    push(1'b0, {1'b0, 2'b10, 7'h40});
    step(2);
    ifa.en = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b0, IDLE_A);
    step(3);
    ifa.en = 1'b1;
    push_frame(1'b0, 7'h3F, 7'h5B);
    step(12);

    // Asynchronous reset in SHOW2, observed between clock edges.
    push_frame(1'b0, 7'h3F, 7'h5B);
    step(7);
    qa.delete();
    #2;
    rst = 1'b1;
    #1;
    check_val("dut_a_async_rst", {ifa.frame_tick, ifa.an_out, ifa.seg_out}, IDLE_A);
    push(1'b0, IDLE_A);
    push(1'b0, IDLE_A);
    step(2);
    rst = 1'b0;
    push_frame(1'b0, 7'h3F, 7'h5B);
    step(12);
    ifa.en = 1'b0;
    qa.delete();

    // No-blanking instance: alternating digits, 8-cycle frame.
    ifb.en = 1'b1;
    push_frame(1'b1, 7'h06, 7'h5B);
    push_frame(1'b1, 7'h06, 7'h5B);
    step(10);
    ifb.seg2_in = 7'h4F;
    step(6);
    push_frame(1'b1, 7'h06, 7'h4F);
    step(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
